apb2axi_rd_issuer: RTL and testbench

APB2AXI_RD_ISSUER -- requirements
Module: apb2axi_rd_issuer

---
 rtl/apb2axi_pkg.sv | 36 +++
 rtl/apb2axi_rd_issuer_if.sv | 31 +++
 rtl/apb2axi_rd_credit.sv | 54 +++++
 rtl/apb2axi_rd_issuer.sv | 105 ++++++++++
 tb/tb_apb2axi_rd_issuer.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB-to-AXI bridge read path.
// Command entry layout, AXI widths and the 4KB-crossing helper.
package apb2axi_pkg;

  localparam int TAG_W      = 3;
  localparam int AXI_ID_W   = TAG_W;
  localparam int AXI_ADDR_W = 32;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic                  is_write;
    logic [TAG_W-1:0]      tag;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
  } cmd_entry_t;

  localparam int CMD_ENTRY_W = $bits(cmd_entry_t);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } rd_state_e;

  // Byte count and end offset are evaluated in 13 bits, matching the
  // check that upstream tooling uses for the same burst descriptors.
  function automatic logic crosses_4k(logic [11:0] offs, logic [7:0] len, logic [2:0] size);
    logic [12:0] bytes;
    logic [12:0] fin;
    bytes = ({5'b0, len} + 13'd1) << size;
    fin   = {1'b0, offs} + bytes;
    return fin > 13'd4096;
  endfunction

endpackage

// File: rtl/apb2axi_rd_issuer_if.sv
// Read-issuer bus bundle: command FIFO pop port, AXI AR channel, R completion.
// master = issuer side, slave = FIFO/AXI/R-tracker side.
interface apb2axi_rd_issuer_if;
  import apb2axi_pkg::*;

  logic                   rd_pop_vld;
  logic [CMD_ENTRY_W-1:0] rd_pop_data;
  logic                   rd_pop_rdy;

  logic                   arvalid;
  logic                   arready;
  logic [AXI_ID_W-1:0]    arid;
  logic [AXI_ADDR_W-1:0]  araddr;
  logic [7:0]             arlen;
  logic [2:0]             arsize;
  logic [1:0]             arburst;

  logic                   rdone_vld;
  logic [AXI_ID_W-1:0]    rdone_id;

  modport master (
    input  rd_pop_vld, rd_pop_data, arready, rdone_vld, rdone_id,
    output rd_pop_rdy, arvalid, arid, araddr, arlen, arsize, arburst
  );

  modport slave (
    output rd_pop_vld, rd_pop_data, arready, rdone_vld, rdone_id,
    input  rd_pop_rdy, arvalid, arid, araddr, arlen, arsize, arburst
  );

endinterface

// File: rtl/apb2axi_rd_credit.sv
// In-flight tag bitmap and outstanding count; set wins over same-cycle clear.
// Lookup/count reflect registered state only, so a completion frees credit next cycle.
module apb2axi_rd_credit #(
  parameter int MAX_OUTST = 4,
  parameter int TAG_W     = 3
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           set_vld,
  input  logic [TAG_W-1:0]               set_tag,
  input  logic                           clr_vld,
  input  logic [TAG_W-1:0]               clr_tag,
  input  logic [TAG_W-1:0]               lookup_tag,
  output logic                           lookup_hit,
  output logic                           clr_miss,
  output logic [$clog2(MAX_OUTST+1)-1:0] cnt
);

  localparam int DEPTH = 1 << TAG_W;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic [DEPTH-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clr_hit;

  always_comb begin
    clr_hit    = clr_vld & inflight_q[clr_tag];
    inflight_d = inflight_q;
    cnt_d      = cnt_q;
    if (clr_hit) inflight_d[clr_tag] = 1'b0;
    if (set_vld) inflight_d[set_tag] = 1'b1;
    // The issuer never sets at MAX_OUTST and only in-flight tags clear, so no wrap.
    case ({set_vld, clr_hit})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      inflight_q <= '0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  assign lookup_hit = inflight_q[lookup_tag];
  assign clr_miss   = clr_vld & ~inflight_q[clr_tag];
  assign cnt        = cnt_q;

endmodule

// File: rtl/apb2axi_rd_issuer.sv
// Pops read commands and issues one AXI AR per entry; accept -> arvalid is 1 cycle.
// Holds AR stable under arready=0; stalls pop on credit limit or tag still in flight.
module apb2axi_rd_issuer
  import apb2axi_pkg::*;
#(
  parameter int MAX_OUTST = 4
) (
  input  logic                           aclk,
  input  logic                           areset,
  apb2axi_rd_issuer_if.master            bus,
  output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
  output logic                           err_unexp,
  output logic                           err_4k
);

  localparam int              CNT_W   = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  rd_state_e             state_q, state_d;
  cmd_entry_t            entry;
  logic                  pop_rdy;
  logic                  accept;
  logic                  tag_busy;
  logic                  clr_miss;
  logic [AXI_ID_W-1:0]   arid_q;
  logic [AXI_ADDR_W-1:0] araddr_q;
  logic [7:0]            arlen_q;
  logic [2:0]            arsize_q;
  logic                  err_unexp_q;
  logic                  err_4k_q;

  assign entry = cmd_entry_t'(bus.rd_pop_data);

  always_comb begin
    state_d = state_q;
    pop_rdy = ~areset & ((state_q == ST_IDLE) | bus.arready)
            & (outst_cnt < MAX_CNT) & ~tag_busy;
    accept  = bus.rd_pop_vld & pop_rdy;
    if (accept) begin
      state_d = ST_ISSUE;
    end else if ((state_q == ST_ISSUE) && bus.arready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      arid_q   <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      arsize_q <= '0;
    end else if (accept) begin
      arid_q   <= entry.tag;
      araddr_q <= entry.addr;
      arlen_q  <= entry.len;
      arsize_q <= entry.size;
    end
  end

  // The burst is issued unchanged; the flag only reports the crossing.
  always_ff @(posedge aclk) begin
    if (areset) begin
      err_unexp_q <= 1'b0;
      err_4k_q    <= 1'b0;
    end else begin
      err_unexp_q <= err_unexp_q | clr_miss;
      err_4k_q    <= err_4k_q | (accept & crosses_4k(entry.addr[11:0], entry.len, entry.size));
    end
  end

  apb2axi_rd_credit #(
    .MAX_OUTST (MAX_OUTST),
    .TAG_W     (TAG_W)
  ) u_credit (
    .aclk       (aclk),
    .areset     (areset),
    .set_vld    (accept),
    .set_tag    (entry.tag),
    .clr_vld    (bus.rdone_vld),
    .clr_tag    (bus.rdone_id),
    .lookup_tag (entry.tag),
    .lookup_hit (tag_busy),
    .clr_miss   (clr_miss),
    .cnt        (outst_cnt)
  );

  assign bus.rd_pop_rdy = pop_rdy;
  assign bus.arvalid    = (state_q == ST_ISSUE);
  assign bus.arid       = arid_q;
  assign bus.araddr     = araddr_q;
  assign bus.arlen      = arlen_q;
  assign bus.arsize     = arsize_q;
  assign bus.arburst    = AXI_BURST_INCR;
  assign err_unexp      = err_unexp_q;
  assign err_4k         = err_4k_q;

endmodule

// File: tb/tb_apb2axi_rd_issuer.sv
// Scenario tasks plus a randomized run, all checked against a tag-set model of the issuer.
module tb_apb2axi_rd_issuer;
  import apb2axi_pkg::*;

  localparam int MAX_OUTST = 4;

  logic       aclk;
  logic       areset;
  logic [2:0] outst_cnt;
  logic       err_unexp;
  logic       err_4k;

  int n_vec;
  int n_err;

  apb2axi_rd_issuer_if bus ();

  apb2axi_rd_issuer #(.MAX_OUTST(MAX_OUTST)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .bus       (bus),
    .outst_cnt (outst_cnt),
    .err_unexp (err_unexp),
    .err_4k    (err_4k)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Reference model: set of tags in flight, the AR currently offered, sticky errors.
  bit         m_inflight [8];
  bit         m_arv;
  cmd_entry_t m_ar;
  bit         m_unexp;
  bit         m_4k;

  function automatic int m_cnt();
    int c = 0;
    for (int t = 0; t < 8; t++) c += m_inflight[t];
    return c;
  endfunction

  function automatic bit m_rdy();
    cmd_entry_t e;
    e = bus.rd_pop_data;
    if (areset) return 1'b0;
    return (!m_arv || bus.arready) && (m_cnt() < MAX_OUTST) && !m_inflight[e.tag];
  endfunction

  function automatic cmd_entry_t mk(bit w, int tag, int addr, int len, int size);
    cmd_entry_t e;
    e.is_write = w;
    e.tag      = tag[2:0];
    e.addr     = addr;
    e.len      = len[7:0];
    e.size     = size[2:0];
    return e;
  endfunction

  // Apply inputs mid-cycle (negedge) and let combinational outputs settle.
  task automatic drive(input bit rst, input bit vld, input cmd_entry_t e,
                       input bit ar_rdy, input bit dv, input int did);
    @(negedge aclk);
    areset          = rst;
    bus.rd_pop_vld  = vld;
    bus.rd_pop_data = e;
    bus.arready     = ar_rdy;
    bus.rdone_vld   = dv;
    bus.rdone_id    = did[2:0];
    #1;
  endtask

  // Advance the model by the cycle whose inputs are currently applied, then clock.
  task automatic adv();
    cmd_entry_t e;
    bit         acc;
    int         bytes;
    e = bus.rd_pop_data;
    if (areset) begin
      for (int t = 0; t < 8; t++) m_inflight[t] = 1'b0;
      m_arv = 0; m_ar = '0; m_unexp = 0; m_4k = 0;
    end else begin
      acc = bus.rd_pop_vld && m_rdy();
      if (bus.rdone_vld) begin
        if (m_inflight[bus.rdone_id]) m_inflight[bus.rdone_id] = 1'b0;
        else m_unexp = 1'b1;
      end
      if (acc) begin
        m_inflight[e.tag] = 1'b1;
        m_ar  = e;
        m_arv = 1'b1;
        bytes = (int'(e.len) + 1) * (1 << e.size);
        if (int'(e.addr % 4096) + bytes > 4096) m_4k = 1'b1;
      end else if (m_arv && bus.arready) begin
        m_arv = 1'b0;
      end
    end
    @(posedge aclk);
  endtask

  task automatic drain();
    for (int t = 0; t < 8; t++) begin
      if (m_inflight[t]) begin
        drive(0, 0, '0, 1, 1, t);
        adv();
      end
    end
    drive(0, 0, '0, 1, 0, 0);
    adv();
  endtask

  task automatic test_reset();
    drive(1, 1, mk(0, 1, 'h40, 0, 0), 1, 0, 0);
    adv();
    drive(1, 1, mk(0, 1, 'h40, 0, 0), 1, 1, 1);
    n_vec++; if (bus.rd_pop_rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy got=%b exp=0", bus.rd_pop_rdy); end
    n_vec++; if (bus.arvalid !== 1'b0) begin n_err++; $display("FAIL reset_arvalid got=%b exp=0", bus.arvalid); end
    n_vec++; if ({bus.arid, bus.araddr, bus.arlen, bus.arsize} !== '0) begin n_err++;
      $display("FAIL reset_payload got id=%0d addr=%h len=%0d size=%0d exp all 0", bus.arid, bus.araddr, bus.arlen, bus.arsize); end
    n_vec++; if ({outst_cnt, err_unexp, err_4k} !== 5'b0) begin n_err++;
      $display("FAIL reset_status got cnt=%0d unexp=%b 4k=%b exp 0/0/0", outst_cnt, err_unexp, err_4k); end
    adv();
  endtask

  task automatic test_single_read();
    cmd_entry_t e;
    e = mk(0, 3, 'h1000, 3, 2);
    drive(0, 1, e, 1, 0, 0);
    n_vec++; if (bus.rd_pop_rdy !== 1'b1) begin n_err++; $display("FAIL single_rdy got=%b exp=1", bus.rd_pop_rdy); end
    n_vec++; if (bus.arvalid !== 1'b0) begin n_err++; $display("FAIL single_arvalid_early got=%b exp=0", bus.arvalid); end
    adv();
    drive(0, 0, e, 1, 0, 0);
    n_vec++; if (bus.arvalid !== 1'b1) begin n_err++; $display("FAIL single_arvalid got=%b exp=1", bus.arvalid); end
    n_vec++; if (bus.arid !== 3'd3 || bus.araddr !== 32'h1000 || bus.arlen !== 8'd3 || bus.arsize !== 3'd2) begin n_err++;
      $display("FAIL single_payload got id=%0d addr=%h len=%0d size=%0d exp 3/1000/3/2", bus.arid, bus.araddr, bus.arlen, bus.arsize); end
    n_vec++; if (bus.arburst !== 2'b01) begin n_err++; $display("FAIL single_arburst got=%b exp=01", bus.arburst); end
    n_vec++; if (outst_cnt !== 3'd1) begin n_err++; $display("FAIL single_cnt1 got=%0d exp=1", outst_cnt); end
    adv();
    drive(0, 0, '0, 1, 1, 3);
    n_vec++; if (bus.arvalid !== 1'b0) begin n_err++; $display("FAIL single_idle got=%b exp=0", bus.arvalid); end
    adv();
    drive(0, 0, '0, 1, 0, 0);
    n_vec++; if (outst_cnt !== 3'd0) begin n_err++; $display("FAIL single_cnt0 got=%0d exp=0", outst_cnt); end
    adv();
  endtask

  task automatic test_backpressure();
    drive(0, 1, mk(0, 5, 'h2040, 7, 3), 1, 0, 0);
    adv();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, mk(0, 6, 'h3000, 1, 1), 0, 0, 0);
      n_vec++; if (bus.arvalid !== 1'b1 || bus.arid !== 3'd5 || bus.araddr !== 32'h2040 || bus.arlen !== 8'd7) begin n_err++;
        $display("FAIL bp_hold[%0d] got v=%b id=%0d addr=%h len=%0d exp 1/5/2040/7", i, bus.arvalid, bus.arid, bus.araddr, bus.arlen); end
      n_vec++; if (bus.rd_pop_rdy !== 1'b0) begin n_err++; $display("FAIL bp_rdy[%0d] got=%b exp=0", i, bus.rd_pop_rdy); end
      adv();
    end
    drive(0, 0, '0, 1, 0, 0);
    n_vec++; if (bus.arvalid !== 1'b1) begin n_err++; $display("FAIL bp_hs got=%b exp=1", bus.arvalid); end
    adv();
    drive(0, 0, '0, 1, 0, 0);
    n_vec++; if (bus.arvalid !== 1'b0) begin n_err++; $display("FAIL bp_idle got=%b exp=0", bus.arvalid); end
    adv();
    drain();
  endtask

  task automatic test_credit_limit();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, mk(0, i, i * 64, 0, 2), 1, 0, 0);
      n_vec++; if (bus.rd_pop_rdy !== 1'b1) begin n_err++; $display("FAIL credit_rdy[%0d] got=%b exp=1", i, bus.rd_pop_rdy); end
      if (i > 0) begin
        n_vec++; if (bus.arvalid !== 1'b1 || bus.arid !== 3'(i - 1)) begin n_err++;
          $display("FAIL credit_b2b[%0d] got v=%b id=%0d exp 1/%0d", i, bus.arvalid, bus.arid, i - 1); end
      end
      adv();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, mk(0, 4, 'h400, 0, 2), 1, 0, 0);
      n_vec++; if (bus.rd_pop_rdy !== 1'b0 || outst_cnt !== 3'd4) begin n_err++;
        $display("FAIL credit_stall[%0d] got rdy=%b cnt=%0d exp 0/4", i, bus.rd_pop_rdy, outst_cnt); end
      adv();
    end
    drive(0, 1, mk(0, 4, 'h400, 0, 2), 1, 1, 1);
    n_vec++; if (bus.rd_pop_rdy !== 1'b0) begin n_err++; $display("FAIL credit_bypass got=%b exp=0", bus.rd_pop_rdy); end
    adv();
    drive(0, 1, mk(0, 4, 'h400, 0, 2), 1, 0, 0);
    n_vec++; if (bus.rd_pop_rdy !== 1'b1) begin n_err++; $display("FAIL credit_freed got=%b exp=1", bus.rd_pop_rdy); end
    adv();
    drive(0, 0, '0, 1, 0, 0);
    n_vec++; if (bus.arvalid !== 1'b1 || bus.arid !== 3'd4) begin n_err++;
      $display("FAIL credit_tag4 got v=%b id=%0d exp 1/4", bus.arvalid, bus.arid); end
    adv();
    drain();
  endtask

  task automatic test_tag_hazard();
    drive(0, 1, mk(0, 2, 'h100, 1, 2), 1, 0, 0);
    adv();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, mk(0, 2, 'h200, 1, 2), 1, 0, 0);
      n_vec++; if (bus.rd_pop_rdy !== 1'b0) begin n_err++; $display("FAIL hazard_stall[%0d] got=%b exp=0", i, bus.rd_pop_rdy); end
      adv();
    end
    drive(0, 1, mk(0, 2, 'h200, 1, 2), 1, 1, 2);
    n_vec++; if (bus.rd_pop_rdy !== 1'b0) begin n_err++; $display("FAIL hazard_same_cycle got=%b exp=0", bus.rd_pop_rdy); end
    adv();
    drive(0, 1, mk(0, 2, 'h200, 1, 2), 1, 0, 0);
    n_vec++; if (bus.rd_pop_rdy !== 1'b1) begin n_err++; $display("FAIL hazard_release got=%b exp=1", bus.rd_pop_rdy); end
    adv();
    drive(0, 1, mk(0, 5, 'h300, 0, 0), 1, 1, 2);
    n_vec++; if (bus.rd_pop_rdy !== 1'b1) begin n_err++; $display("FAIL hazard_unrelated_rdy got=%b exp=1", bus.rd_pop_rdy); end
    adv();
    drive(0, 0, '0, 1, 0, 0);
    n_vec++; if (outst_cnt !== 3'(m_cnt()) || m_cnt() != 1) begin n_err++;
      $display("FAIL hazard_cnt got=%0d exp=1", outst_cnt); end
    adv();
    drain();
  endtask

  task automatic test_errors();
    drive(0, 0, '0, 1, 1, 7);
    adv();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, '0, 1, 0, 0);
      n_vec++; if (err_unexp !== 1'b1 || outst_cnt !== 3'd0) begin n_err++;
        $display("FAIL err_unexp[%0d] got unexp=%b cnt=%0d exp 1/0", i, err_unexp, outst_cnt); end
      adv();
    end
    n_vec++; if (err_4k !== 1'b0) begin n_err++; $display("FAIL err_4k_clear got=%b exp=0", err_4k); end
    // 0xFF0 + 16 bytes ends exactly on the boundary; 0xFF4 + 16 spills over.
    drive(0, 1, mk(0, 1, 'hFF0, 3, 2), 1, 0, 0);
    adv();
    drive(0, 0, '0, 1, 0, 0);
    n_vec++; if (err_4k !== m_4k || bus.arvalid !== 1'b1 || bus.araddr !== 32'hFF0) begin n_err++;
      $display("FAIL err_4k_fit got 4k=%b v=%b addr=%h exp %b/1/ff0", err_4k, bus.arvalid, bus.araddr, m_4k); end
    adv();
    drive(0, 1, mk(1, 2, 'hFF4, 3, 2), 1, 0, 0);
    adv();
    drive(0, 0, '0, 1, 0, 0);
    n_vec++; if (err_4k !== 1'b1 || bus.arvalid !== 1'b1 || bus.araddr !== 32'hFF4) begin n_err++;
      $display("FAIL err_4k_cross got 4k=%b v=%b addr=%h exp 1/1/ff4", err_4k, bus.arvalid, bus.araddr); end
    adv();
    drain();
  endtask

  task automatic test_reset_mid_issue();
    drive(0, 1, mk(0, 0, 'h10, 0, 0), 1, 0, 0); adv();
    drive(0, 1, mk(0, 1, 'h20, 0, 0), 1, 0, 0); adv();
    drive(0, 1, mk(0, 2, 'h30, 0, 0), 1, 0, 0); adv();
    drive(0, 0, '0, 0, 0, 0);
    n_vec++; if (bus.arvalid !== 1'b1 || outst_cnt !== 3'd3) begin n_err++;
      $display("FAIL rstmid_pre got v=%b cnt=%0d exp 1/3", bus.arvalid, outst_cnt); end
    adv();
    drive(1, 1, mk(0, 3, 'h40, 0, 0), 0, 1, 0);
    n_vec++; if (bus.rd_pop_rdy !== 1'b0) begin n_err++; $display("FAIL rstmid_rdy got=%b exp=0", bus.rd_pop_rdy); end
    adv();
    drive(0, 0, '0, 0, 0, 0);
    n_vec++; if (bus.arvalid !== 1'b0 || outst_cnt !== 3'd0 || err_unexp !== 1'b0 || err_4k !== 1'b0) begin n_err++;
      $display("FAIL rstmid_post got v=%b cnt=%0d unexp=%b 4k=%b exp 0/0/0/0", bus.arvalid, outst_cnt, err_unexp, err_4k); end
    adv();
  endtask

  task automatic test_random();
    cmd_entry_t e;
    bit         vld, ar_rdy, dv;
    int         did;
    int         live [$];
    for (int cyc = 0; cyc < 600; cyc++) begin
      e = mk($urandom_range(0, 1), $urandom_range(0, 7), $urandom, $urandom_range(0, 255), $urandom_range(0, 4));
      vld    = ($urandom_range(0, 3) != 0);
      ar_rdy = ($urandom_range(0, 9) < 7);
      live.delete();
      for (int t = 0; t < 8; t++) if (m_inflight[t]) live.push_back(t);
      dv  = 1'b0;
      did = 0;
      if (live.size() > 0 && $urandom_range(0, 2) == 0) begin
        dv  = 1'b1;
        did = live[$urandom_range(0, live.size() - 1)];
      end else if ($urandom_range(0, 39) == 0) begin
        dv  = 1'b1;
        did = $urandom_range(0, 7);
      end
      drive(0, vld, e, ar_rdy, dv, did);
      n_vec++; if (bus.rd_pop_rdy !== m_rdy()) begin n_err++;
        $display("FAIL rnd_rdy[%0d] got=%b exp=%b", cyc, bus.rd_pop_rdy, m_rdy()); end
      n_vec++; if (bus.arvalid !== m_arv) begin n_err++;
        $display("FAIL rnd_arvalid[%0d] got=%b exp=%b", cyc, bus.arvalid, m_arv); end
      if (m_arv) begin
        n_vec++; if (bus.arid !== m_ar.tag || bus.araddr !== m_ar.addr || bus.arlen !== m_ar.len || bus.arsize !== m_ar.size) begin n_err++;
          $display("FAIL rnd_payload[%0d] got id=%0d addr=%h len=%0d size=%0d exp %0d/%h/%0d/%0d", cyc,
                   bus.arid, bus.araddr, bus.arlen, bus.arsize, m_ar.tag, m_ar.addr, m_ar.len, m_ar.size); end
      end
      n_vec++; if (outst_cnt !== 3'(m_cnt())) begin n_err++;
        $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", cyc, outst_cnt, m_cnt()); end
      n_vec++; if (err_unexp !== m_unexp || err_4k !== m_4k) begin n_err++;
        $display("FAIL rnd_err[%0d] got unexp=%b 4k=%b exp %b/%b", cyc, err_unexp, err_4k, m_unexp, m_4k); end
      adv();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    areset          = 1'b1;
    bus.rd_pop_vld  = 1'b0;
    bus.rd_pop_data = '0;
    bus.arready     = 1'b0;
    bus.rdone_vld   = 1'b0;
    bus.rdone_id    = '0;
    for (int t = 0; t < 8; t++) m_inflight[t] = 1'b0;
    m_arv = 0; m_ar = '0; m_unexp = 0; m_4k = 0;

    test_reset();
    test_single_read();
    test_backpressure();
    test_credit_limit();
    test_tag_hazard();
    test_errors();
    test_reset_mid_issue();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
